branch_predictor: RTL
=====================

# branch_predictor

Dynamic conditional-branch predictor for the fetch stage: a table of 2-bit saturating counters indexed by PC, read one cycle ahead of decode and trained by the resolved outcome from the execute-stage branch comparator. Fetch supplies a PC and receives a registered taken/not-taken hint. Execute later returns the comparator's taken bit together with the prediction and history that were issued, so the table can be updated and mispredicts counted.

## Interface
Parameters:
- ENTRIES, 64, number of counters; power of 2, 4..1024.
- IDX_W, $clog2(ENTRIES), index width (derived; not overridden).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- pred_valid  input  1  lookup request this cycle.
- pred_pc  input  32  PC of the fetched branch.
- pred_out_valid  output  1  registered pred_valid.
- pred_taken  output  1  prediction, valid when pred_out_valid.
- pred_hist  output  IDX_W  history used for this lookup; zero when BP_GSHARE_EN is undefined.
- upd_valid  input  1  resolved conditional branch this cycle.
- upd_pc  input  32  PC of the resolved branch.
- upd_taken  input  1  comparator result (1 = taken).
- upd_pred  input  1  pred_taken originally issued for this branch.
- upd_hist  input  IDX_W  pred_hist originally issued for this branch.
- mispredict  output  1  registered: previous-cycle upd_valid & (upd_taken != upd_pred).
- mispredict_cnt  output  32  saturating count of mispredicts.

## Operation
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; prediction = counter[1].
- Index: pc[IDX_W+1:2] (PC[1:0] ignored); with BP_GSHARE_EN, index XORed with history.
- Lookup: when pred_valid is high, the counter at the lookup index is sampled into an output register. When pred_valid is low, pred_out_valid is 0 next cycle and pred_taken/pred_hist hold their last values.
- Update: when upd_valid is high, the counter at the update index increments if upd_taken, else decrements; it saturates at 11/00.
- Index for update uses upd_pc and upd_hist, never the live history.
- mispredict_cnt increments on each registered mispredict and saturates at 0xFFFF_FFFF (no wrap).
- Lookup and update in the same cycle to the same index: lookup returns the pre-update counter (read-before-write), and the update still commits.
- Lookup and update at different indices are independent; both occur every cycle if requested.
- Reset (asynchronous, any time, including mid-update): all counters = 01, pred_out_valid = 0, pred_taken = 0, pred_hist = 0, mispredict = 0, mispredict_cnt = 0, history = 0. The first lookup after reset therefore predicts not-taken.

## Timing
- Lookup latency 1 cycle: pred_valid at edge N gives pred_out_valid/pred_taken valid after edge N+1.
- Update visible to a lookup issued in the cycle after upd_valid.
- mispredict asserted for one cycle, following the upd_valid cycle. mispredict_cnt reflects it one cycle after mispredict.
- No backpressure; both ports accept one request per cycle.
- Lookup path: index decode + counter mux into register. No combinational path from any input to any output.

## Configuration
- BP_GSHARE_EN defined: an IDX_W-bit global history register shifts left on every upd_valid, inserting upd_taken at bit 0. The lookup index is pc index XOR history. pred_hist outputs the history used.
  - Simultaneous lookup and update: the lookup uses the pre-shift history.
- BP_GSHARE_EN undefined: no history register; index is the PC bits only; pred_hist is tied to 0; upd_hist is ignored.

## Structure
- Package bp_pkg holds:
  - counter encoding localparams (SNT, WNT, WT, ST)
  - reset counter value (WNT)
  - counter typedef logic [1:0]
- One sub-module bp_sat2: combinational 2-bit saturating next-state (inputs cur, taken; output nxt). Used on the update path.
- Counter table is flops (asynchronous reset required), not inferred RAM.

## Test plan
- Reset check: assert rst_n=0 mid-run, release, lookup PC 0x100 -> pred_out_valid=1, pred_taken=0 next cycle, mispredict_cnt=0.
- Training: three updates PC 0x100 taken (upd_pred=0) -> lookup 0x100 gives taken; mispredict_cnt=1 (only the first upd_pred mismatches if bench issues correct preds after) — bench drives upd_pred from prior lookup, expects count 1.
- Saturation/hysteresis: train 0x200 to 11 with 5 taken updates, one not-taken -> still taken; second not-taken -> not-taken.
- Aliasing: ENTRIES=64, train 0x004 taken twice -> lookup 0x104 (same index) predicts taken; 0x008 still not-taken.
- Same-cycle collision: counter at 0x300 = 01, lookup and taken update 0x300 together -> pred_taken=0, lookup next cycle -> 1.
- BP_GSHARE_EN: updates taken,taken (history 0b11) -> lookup 0x00C uses index 3^3=0 and returns pred_hist=3. Counter mispredict saturation forced via 2^32 mispredicts in a reduced-width test build, or a forced preload, -> holds 0xFFFF_FFFF.

Source files
------------

// File: rtl/bp_pkg.sv
// bp_pkg: shared definitions for the branch predictor.
// Holds the 2-bit counter type, the counter encodings and the counter reset value.
// Optional feature macro used by the top: BP_GSHARE_EN.
package bp_pkg;

  typedef logic [1:0] ctr_t;

  // Saturating counter states; the prediction is counter bit 1.
  localparam ctr_t SNT = 2'b00;
  localparam ctr_t WNT = 2'b01;
  localparam ctr_t WT  = 2'b10;
  localparam ctr_t ST  = 2'b11;

  // Weakly not-taken, so one taken outcome flips the prediction.
  localparam ctr_t CTR_RESET = WNT;

endpackage

// File: rtl/bp_sat2.sv
// bp_sat2: combinational next-state for a 2-bit saturating counter.
// Ports:
//   cur   - current counter value
//   taken - resolved outcome (1 = taken, count up; 0 = count down)
//   nxt   - updated counter value, saturating at ST / SNT
module bp_sat2
  import bp_pkg::*;
(
  input  ctr_t cur,
  input  logic taken,
  output ctr_t nxt
);

  always_comb begin
    nxt = cur;
    unique case (cur)
      SNT: nxt = taken ? WNT : SNT;
      WNT: nxt = taken ? WT  : SNT;
      WT:  nxt = taken ? ST  : WNT;
      ST:  nxt = taken ? ST  : WT;
      default: nxt = cur;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: table of 2-bit saturating counters indexed by PC.
// Fetch-side lookup is registered (1-cycle latency); execute-side update
// trains the table and counts mispredicts (saturating 32-bit counter).
// Optional feature: define BP_GSHARE_EN to XOR a global outcome history
// into both the lookup and the update index.
// Ports:
//   clk, rst_n                      - clock, asynchronous active-low reset
//   pred_valid, pred_pc             - lookup request
//   pred_out_valid, pred_taken,
//   pred_hist                       - registered lookup result and history used
//   upd_valid, upd_pc, upd_taken,
//   upd_pred, upd_hist              - resolved branch with its issued prediction/history
//   mispredict, mispredict_cnt      - registered mispredict pulse and saturating count
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pred_valid,
  input  logic [31:0]      pred_pc,
  output logic             pred_out_valid,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_hist,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic             upd_pred,
  input  logic [IDX_W-1:0] upd_hist,
  output logic             mispredict,
  output logic [31:0]      mispredict_cnt
);

  ctr_t             table_q [ENTRIES];
  ctr_t             table_d [ENTRIES];
  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] up_idx;
  logic [IDX_W-1:0] cur_hist;
  ctr_t             up_nxt;

  logic             pred_out_valid_q, pred_out_valid_d;
  logic             pred_taken_q, pred_taken_d;
  logic [IDX_W-1:0] pred_hist_q, pred_hist_d;
  logic             mispredict_q, mispredict_d;
  logic [31:0]      mispredict_cnt_q, mispredict_cnt_d;

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] hist_q, hist_d;
  logic             unused_pc_bits;

  // Update uses the history issued with the branch, not the live one.
  assign cur_hist = hist_q;
  assign lk_idx   = pred_pc[IDX_W+1:2] ^ hist_q;
  assign up_idx   = upd_pc[IDX_W+1:2] ^ upd_hist;
  assign unused_pc_bits = ^{pred_pc[31:IDX_W+2], pred_pc[1:0],
                            upd_pc[31:IDX_W+2], upd_pc[1:0]};

  always_comb begin
    hist_d = hist_q;
    if (upd_valid) hist_d = {hist_q[IDX_W-2:0], upd_taken};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist_q <= '0;
    else        hist_q <= hist_d;
  end
`else
  logic unused_pc_bits;

  assign cur_hist = '0;
  assign lk_idx   = pred_pc[IDX_W+1:2];
  assign up_idx   = upd_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{pred_pc[31:IDX_W+2], pred_pc[1:0],
                            upd_pc[31:IDX_W+2], upd_pc[1:0], upd_hist};
`endif

  bp_sat2 u_sat2 (
    .cur   (table_q[up_idx]),
    .taken (upd_taken),
    .nxt   (up_nxt)
  );

  // Lookup reads table_q (pre-update), giving read-before-write on collision.
  always_comb begin
    pred_out_valid_d = pred_valid;
    pred_taken_d     = pred_taken_q;
    pred_hist_d      = pred_hist_q;
    if (pred_valid) begin
      pred_taken_d = table_q[lk_idx][1];
      pred_hist_d  = cur_hist;
    end

    mispredict_d     = upd_valid & (upd_taken != upd_pred);
    mispredict_cnt_d = mispredict_cnt_q;
    if (mispredict_q && (mispredict_cnt_q != 32'hFFFF_FFFF))
      mispredict_cnt_d = mispredict_cnt_q + 32'd1;

    table_d = table_q;
    if (upd_valid) table_d[up_idx] = up_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= CTR_RESET;
      pred_out_valid_q <= 1'b0;
      pred_taken_q     <= 1'b0;
      pred_hist_q      <= '0;
      mispredict_q     <= 1'b0;
      mispredict_cnt_q <= '0;
    end else begin
      table_q          <= table_d;
      pred_out_valid_q <= pred_out_valid_d;
      pred_taken_q     <= pred_taken_d;
      pred_hist_q      <= pred_hist_d;
      mispredict_q     <= mispredict_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign pred_out_valid = pred_out_valid_q;
  assign pred_taken     = pred_taken_q;
  assign pred_hist      = pred_hist_q;
  assign mispredict     = mispredict_q;
  assign mispredict_cnt = mispredict_cnt_q;

endmodule
